taillight_sequencer: RTL

// Thunderbird taillight controller. Owns and sequences a restartable step timer
// (one-pulse-per-period tick generator) and drives the three left and three

---
 rtl/tbird_pkg.sv | 30 +++
 rtl/step_timer.sv | 34 +++
 rtl/taillight_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/tbird_pkg.sv
// Shared types and lamp patterns for the Thunderbird taillight controller.
package tbird_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        L1   = 4'd1,
        L2   = 4'd2,
        L3   = 4'd3,
        LGAP = 4'd4,
        R1   = 4'd5,
        R2   = 4'd6,
        R3   = 4'd7,
        RGAP = 4'd8,
        HON  = 4'd9,
        HOFF = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_t;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_3   = 3'b111;

endpackage

// File: rtl/step_timer.sv
// Restartable step timer: one registered Tick per StepCount enabled cycles.
module step_timer #(
    parameter int StepCount = 25_000_000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic Restart,
    input  logic Enable,
    output logic Tick
);

    localparam int W = $clog2(StepCount);
    localparam logic [W-1:0] LAST = W'(StepCount - 1);
    localparam logic [W-1:0] PRE  = W'(StepCount - 2);

    logic [W-1:0] count;

    // Tick is set on the edge that loads LAST, so it is high while count==LAST.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
            Tick  <= 1'b0;
        end else if (Restart) begin
            count <= '0;
            Tick  <= 1'b0;
        end else if (Enable) begin
            count <= (count == LAST) ? '0 : count + W'(1);
            Tick  <= (count == PRE);
        end else begin
            Tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Thunderbird taillight controller: mode decode, step FSM and lamp outputs.
module taillight_sequencer
    import tbird_pkg::*;
#(
    parameter int StepCount = 25_000_000
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Left,
    input  logic       Right,
    input  logic       Hazard,
    output logic [2:0] Lamps_L,
    output logic [2:0] Lamps_R,
    output logic       Tick
);

    mode_t  mode;
    mode_t  mode_q;
    state_t state;
    state_t nxt;
    logic   change;

    function automatic state_t entry(input mode_t m);
        case (m)
            LEFT:    return L1;
            RIGHT:   return R1;
            HAZ:     return HON;
            default: return IDLE;
        endcase
    endfunction

    function automatic state_t advance(input state_t s);
        case (s)
            L1:      return L2;
            L2:      return L3;
            L3:      return LGAP;
            LGAP:    return L1;
            R1:      return R2;
            R2:      return R3;
            R3:      return RGAP;
            RGAP:    return R1;
            HON:     return HOFF;
            HOFF:    return HON;
            default: return IDLE;
        endcase
    endfunction

    function automatic logic [2:0] lamp_l(input state_t s);
        case (s)
            L1:      return LAMP_1;
            L2:      return LAMP_2;
            L3:      return LAMP_3;
            HON:     return LAMP_3;
            default: return LAMP_OFF;
        endcase
    endfunction

    function automatic logic [2:0] lamp_r(input state_t s);
        case (s)
            R1:      return LAMP_1;
            R2:      return LAMP_2;
            R3:      return LAMP_3;
            HON:     return LAMP_3;
            default: return LAMP_OFF;
        endcase
    endfunction

    always_comb begin
        mode = NONE;
        if (Hazard || (Left && Right)) mode = HAZ;
        else if (Left)                 mode = LEFT;
        else if (Right)                mode = RIGHT;
    end

    assign change = (mode != mode_q);

    step_timer #(.StepCount(StepCount)) u_timer (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Restart (change || (mode == NONE)),
        .Enable  (mode_q != NONE),
        .Tick    (Tick)
    );

    // Illegal encodings fall to IDLE, and IDLE re-enters the active mode.
    always_comb begin
        nxt = state;
        if (change || mode == NONE)
            nxt = entry(mode);
        else if (state == IDLE)
            nxt = entry(mode);
        else if (Tick)
            nxt = advance(state);
        else if (state > HOFF)
            nxt = IDLE;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            mode_q  <= NONE;
            state   <= IDLE;
            Lamps_L <= LAMP_OFF;
            Lamps_R <= LAMP_OFF;
        end else begin
            mode_q  <= mode;
            state   <= nxt;
            Lamps_L <= lamp_l(nxt);
            Lamps_R <= lamp_r(nxt);
        end
    end

endmodule
